// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave stream block.
//   state_e      : frame FSM states
//   DATABITS_DEF : default word width
//   cnt_w()      : bit-counter width able to hold 0..databits
package spi_pkg;

  localparam int DATABITS_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int cnt_w(input int databits);
    return $clog2(databits + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus edge detect.
//   clk, reset_n : system clock, async active-low reset
//   din          : asynchronous input
//   level        : synchronized level
//   rise, fall   : one-cycle pulses on synchronized level transitions
// RST_VAL sets both the synchronizer and the delayed copy, so reset never
// produces a spurious edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   level_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_pipe <= {SYNC_STAGES{RST_VAL}};
      level_d   <= RST_VAL;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], din};
      level_d   <= sync_pipe[SYNC_STAGES-1];
    end
  end

  assign level = sync_pipe[SYNC_STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule

// File: rtl/spi_slave_stream.sv
// SPI slave, CPOL=0 CPHA=0, MSB first, oversampled in the clk domain.
//   SCLK, SS_n, MOSI     : asynchronous SPI inputs
//   MISO, MISO_oe        : registered slave data and its output enable
//   tx_data/valid/ready  : transmit stream into a one-deep holding register
//   rx_data/valid/ready  : received words
//   frame_active         : synchronized SS_n asserted
//   rx_overrun           : sticky, word completed while rx_valid still set
//   tx_underrun          : sticky, word load found the holding register empty
//   clear_errors         : pulse clearing both sticky flags (a same-cycle set wins)
module spi_slave_stream
  import spi_pkg::*;
#(
  parameter int DATABITS    = DATABITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                SCLK,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic                MISO_oe,
  input  logic [DATABITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [DATABITS-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                frame_active,
  output logic                rx_overrun,
  output logic                tx_underrun,
  input  logic                clear_errors
);

  localparam int CW = cnt_w(DATABITS);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .din(SCLK),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset_n(reset_n), .din(SS_n),
    .level(ss_s), .rise(ss_rise), .fall(ss_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .din(MOSI),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  state_e              state, state_nxt;
  logic [CW-1:0]       bitcnt;
  logic [DATABITS-1:0] rx_shift, rx_shift_nxt;
  logic [DATABITS-1:0] tx_shift, holding;
  logic                primed;
  logic                load_word, shift_in, word_done, tx_shift_en;
  logic                tx_xfer, set_ovr, set_unr;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_word   = 1'b0;
    shift_in    = 1'b0;
    word_done   = 1'b0;
    tx_shift_en = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt = SHIFT;
          load_word = 1'b1;
        end
      end
      SHIFT: begin
        // Deselect aborts any partial word; SCLK edges that cycle are dropped.
        if (ss_rise) begin
          state_nxt = IDLE;
        end else if (sclk_rise) begin
          shift_in  = 1'b1;
          word_done = (bitcnt == CW'(DATABITS - 1));
        end else if (sclk_fall) begin
          // Fall with bitcnt==0 follows a completed word: fetch the next one.
          if (bitcnt != '0) tx_shift_en = 1'b1;
          else              load_word   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_shift_nxt = {rx_shift[DATABITS-2:0], mosi_s};
  assign tx_xfer      = tx_valid & ~primed;
  assign set_ovr      = word_done & rx_valid & ~rx_ready;
  assign set_unr      = load_word & ~primed;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt      <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_shift    <= '0;
      holding     <= '0;
      primed      <= 1'b0;
      MISO        <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (state_nxt != SHIFT || word_done) bitcnt <= '0;
      else if (shift_in)                   bitcnt <= bitcnt + 1'b1;

      if (shift_in) rx_shift <= rx_shift_nxt;

      if (word_done) begin
        rx_data  <= rx_shift_nxt;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end

      // Load reads the pre-transfer holding state: no same-cycle bypass.
      if (load_word)        tx_shift <= primed ? holding : '0;
      else if (tx_shift_en) tx_shift <= tx_shift << 1;

      if (tx_xfer) holding <= tx_data;
      if (tx_xfer)        primed <= 1'b1;
      else if (load_word) primed <= 1'b0;

      MISO <= tx_shift[DATABITS-1];

      if (set_ovr)           rx_overrun <= 1'b1;
      else if (clear_errors) rx_overrun <= 1'b0;

      if (set_unr)           tx_underrun <= 1'b1;
      else if (clear_errors) tx_underrun <= 1'b0;
    end
  end

  assign tx_ready     = ~primed;
  assign frame_active = ~ss_s;
  assign MISO_oe      = ~ss_s;

endmodule

// File: tb/tb_spi_slave_stream.sv
// Bench for spi_slave_stream: SPI master at clk/20, behavioural holding-register
// model for MISO and underrun, and a scoreboard monitor for received words.
module tb_spi_slave_stream;

  localparam int DB   = 8;
  localparam int SYNC = 2;
  localparam int HALF = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          SCLK = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
  logic          MISO, MISO_oe;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0, tx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid, rx_ready = 1'b1;
  logic          frame_active, rx_overrun, tx_underrun;
  logic          clear_errors = 1'b0;

  spi_slave_stream #(.DATABITS(DB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_active(frame_active), .rx_overrun(rx_overrun),
    .tx_underrun(tx_underrun), .clear_errors(clear_errors));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [DB-1:0] exp_q[$];
  bit            hold_full = 0;
  logic [DB-1:0] hold_val = '0;
  bit            exp_unr = 0;
  logic [DB-1:0] fw[4];
  logic [DB-1:0] tw[4];
  bit            tv[4];
  logic [DB-1:0] mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: every rx handshake must match the next expected word
  initial forever begin
    @(negedge clk);
    if (reset_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rx_unexpected: got %0h want none", rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rx_word", 32'(rx_data), 32'(mon_e));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A word load takes the held tx word if present, else sends zeros and flags underrun.
  function automatic logic [DB-1:0] model_load();
    if (hold_full) begin
      hold_full = 0;
      return hold_val;
    end
    exp_unr = 1;
    return '0;
  endfunction

  task automatic tx_push(input logic [DB-1:0] v);
    int n = 0;
    while (!tx_ready && n < 200) begin wait_clk(1); n++; end
    chk("tx_ready_wait", 32'(tx_ready), 1);
    tx_data = v; tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    hold_full = 1; hold_val = v;
  endtask

  task automatic clear_tv();
    for (int j = 0; j < 4; j++) tv[j] = 0;
  endtask

  task automatic check_reset();
    chk("rst_miso", 32'(MISO), 0);
    chk("rst_miso_oe", 32'(MISO_oe), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_frame_active", 32'(frame_active), 0);
    chk("rst_rx_overrun", 32'(rx_overrun), 0);
    chk("rst_tx_underrun", 32'(tx_underrun), 0);
  endtask

  task automatic post_frame(input bit exp_ovr);
    chk("rx_overrun", 32'(rx_overrun), 32'(exp_ovr));
    chk("tx_underrun", 32'(tx_underrun), 32'(exp_unr));
    clear_errors = 1'b1;
    wait_clk(1);
    clear_errors = 1'b0;
    exp_unr = 0;
    chk("ovr_cleared", 32'(rx_overrun), 0);
    chk("unr_cleared", 32'(tx_underrun), 0);
  endtask

  // Master frame: fw[] on MOSI, tv/tw[j] pushed mid-word j for the load that follows it.
  task automatic run_frame(input int nw, input int abort_bits, input bit sync_rdy,
                           input bit auto_push);
    logic [DB-1:0] exp_tx, got;
    int nb, t0;
    t0 = cyc;
    exp_tx = model_load();
    SS_n = 1'b0;
    fork
      begin
        wait_clk(HALF);
        for (int k = 0; k < nw; k++) begin
          nb = (abort_bits > 0 && k == nw - 1) ? abort_bits : DB;
          got = '0;
          for (int i = 0; i < nb; i++) begin
            MOSI = fw[k][DB-1-i];
            wait_clk(HALF);
            got[DB-1-i] = MISO;
            if (i == DB - 1 && auto_push) exp_q.push_back(fw[k]);
            SCLK = 1'b1;
            if (sync_rdy && i == DB - 1) begin
              // rx_ready high exactly in the cycle the word completes
              repeat (SYNC) @(posedge clk);
              #1 rx_ready = 1'b1;
              @(posedge clk);
              #1 rx_ready = 1'b0;
              wait_clk(HALF - SYNC - 1);
            end else begin
              wait_clk(HALF);
            end
            SCLK = 1'b0;
          end
          if (nb == DB) begin
            chk("miso_word", 32'(got), 32'(exp_tx));
            exp_tx = model_load();
          end
        end
        wait_clk(HALF);
        SS_n = 1'b1;
        wait_clk(HALF);
      end
      begin
        for (int j = 0; j < nw; j++) begin
          while (cyc < t0 + 40 + 160 * j) wait_clk(1);
          if (tv[j]) tx_push(tw[j]);
        end
      end
    join
  endtask

  initial begin
    clear_tv();
    #12;
    check_reset();
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(5);

    // 1: single word with preloaded tx
    tx_push(8'h3C);
    chk("tx_ready_primed", 32'(tx_ready), 0);
    fw[0] = 8'hA5;
    run_frame(1, 0, 0, 1);
    chk("tx_ready_after", 32'(tx_ready), 1);
    post_frame(0);

    // 2: two words, tx refilled during each word
    tx_push(8'h11);
    fw[0] = 8'hF0; fw[1] = 8'h0F;
    tw[0] = 8'h22; tv[0] = 1;
    tw[1] = 8'h33; tv[1] = 1;
    run_frame(2, 0, 0, 1);
    clear_tv();
    post_frame(0);

    // 3: no tx preload
    fw[0] = 8'h55;
    run_frame(1, 0, 0, 1);
    post_frame(0);

    // 4: overrun, then consume exactly on completion
    rx_ready = 1'b0;
    fw[0] = 8'h01; fw[1] = 8'h02;
    run_frame(2, 0, 0, 0);
    chk("ovr_rx_data", 32'(rx_data), 8'h02);
    chk("ovr_rx_valid", 32'(rx_valid), 1);
    post_frame(1);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    fw[0] = 8'h03;
    run_frame(1, 0, 1, 0);
    chk("same_cyc_rx_data", 32'(rx_data), 8'h03);
    chk("same_cyc_rx_valid", 32'(rx_valid), 1);
    rx_ready = 1'b1;
    wait_clk(3);
    post_frame(0);

    // 5: abort after 3 rises, then a full frame
    fw[0] = 8'hFF;
    run_frame(1, 3, 0, 1);
    chk("abort_frame_active", 32'(frame_active), 0);
    chk("abort_rx_valid", 32'(rx_valid), 0);
    post_frame(0);
    tx_push(8'h96);
    fw[0] = 8'hC3;
    run_frame(1, 0, 0, 1);
    post_frame(0);

    // 6: reset mid-word
    tx_push(8'h9A);
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 4; i++) begin
      MOSI = 1'($urandom_range(1));
      wait_clk(HALF); SCLK = 1'b1;
      wait_clk(HALF); SCLK = 1'b0;
    end
    wait_clk(2);
    reset_n = 1'b0;
    #1;
    check_reset();
    SS_n = 1'b1; SCLK = 1'b0;
    wait_clk(4);
    reset_n = 1'b1;
    hold_full = 0; exp_unr = 0;
    wait_clk(4);
    tx_push(8'($urandom));
    fw[0] = 8'h7E;
    run_frame(1, 0, 0, 1);
    post_frame(0);

    // random frames of 1..3 words with random tx refills
    for (int r = 0; r < 8; r++) begin
      int nw;
      nw = int'($urandom_range(3, 1));
      if ($urandom_range(1) == 1) tx_push(8'($urandom));
      for (int k = 0; k < nw; k++) begin
        fw[k] = 8'($urandom);
        tw[k] = 8'($urandom);
        tv[k] = ($urandom_range(1) == 1);
      end
      run_frame(nw, 0, 0, 1);
      clear_tv();
      post_frame(0);
    end

    wait_clk(20);
    chk("rx_queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
